// File: rtl/mcs4_rom_bank.sv
// rtl/mcs4_rom_bank.sv - multi-chip i4001-style ROM bank on the 4-bit MCS-4 bus
//
// Emulates NUM_ROMS consecutive ROM chips starting at chip BASE_CHIP. Tracks
// the 8-phase 4004 instruction cycle from SYNC and clk2 falls, fetches opcode
// bytes from an external synchronous program store, and implements the
// SRC/WRR/RDR I/O ports of every emulated chip.
//
// Ports:
//   sysclk    system clock, all logic on its rising edge
//   reset_n   asynchronous active-low reset
//   clk1/clk2 4004 two-phase clock levels (only clk2 falls mark phases)
//   sync      SYNC from the CPU
//   cmrom     CM-ROM from the CPU
//   data_in   bus sample
//   data_out  bus drive value
//   data_oe   bus drive enable
//   rom_addr  {chip index, addr[7:0]} to the program store
//   rom_data  program-store byte, valid 1 sysclk after rom_addr
//   io_in     port input levels, chip k on [4k+3:4k]
//   io_out    port output latches, chip k on [4k+3:4k]
module mcs4_rom_bank #(
  parameter int                    NUM_ROMS  = 4,
  parameter int                    BASE_CHIP = 0,
  parameter logic [4*NUM_ROMS-1:0] IO_OUTPUT = '1,
  parameter int                    AW        = $clog2(NUM_ROMS) + 8
) (
  input  logic                  sysclk,
  input  logic                  reset_n,
  input  logic                  clk1,
  input  logic                  clk2,
  input  logic                  sync,
  input  logic                  cmrom,
  input  logic [3:0]            data_in,
  output logic [3:0]            data_out,
  output logic                  data_oe,
  output logic [AW-1:0]         rom_addr,
  input  logic [7:0]            rom_data,
  input  logic [4*NUM_ROMS-1:0] io_in,
  output logic [4*NUM_ROMS-1:0] io_out
);

  localparam logic [2:0] PH_A1 = 3'd0;
  localparam logic [2:0] PH_A2 = 3'd1;
  localparam logic [2:0] PH_A3 = 3'd2;
  localparam logic [2:0] PH_M1 = 3'd3;
  localparam logic [2:0] PH_M2 = 3'd4;
  localparam logic [2:0] PH_X1 = 3'd5;
  localparam logic [2:0] PH_X2 = 3'd6;
  localparam logic [2:0] PH_X3 = 3'd7;

  // Phases are delimited by clk2 falls alone; clk1 carries no extra information.
  logic unused_clk1;
  assign unused_clk1 = clk1;

  logic                  clk2_q;
  logic [2:0]            phase_q, phase_d;
  logic                  valid_q, valid_d;
  logic [7:0]            addr_lo_q, addr_lo_d;
  logic                  sel_q, sel_d;
  logic [3:0]            opa_q, opa_d;
  logic                  iocmd_q, iocmd_d;
  logic [3:0]            src_chip_q, src_chip_d;
  logic [4*NUM_ROMS-1:0] io_out_q, io_out_d;
  logic                  data_oe_q, data_oe_d;
  logic [3:0]            data_out_q, data_out_d;
  logic [AW-1:0]         rom_addr_q, rom_addr_d;

  logic       phase_ev;
  logic [3:0] fetch_idx;
  logic [3:0] src_idx;
  logic       src_owned;
  logic       rdr_go;
  logic [3:0] rdr_val;

  function automatic logic chip_owned(input logic [3:0] chip);
    chip_owned = ({1'b0, chip} >= 5'(BASE_CHIP)) &&
                 ({1'b0, chip} <  5'(BASE_CHIP + NUM_ROMS));
  endfunction

  assign phase_ev  = clk2_q & ~clk2;
  assign fetch_idx = data_in - 4'(BASE_CHIP);
  assign src_idx   = src_chip_q - 4'(BASE_CHIP);
  assign src_owned = chip_owned(src_chip_q);
  assign rdr_go    = iocmd_q && (opa_q == 4'hA) && src_owned;

  // RDR value: input bits read the pin, output bits read back their latch.
  always_comb begin
    rdr_val = 4'h0;
    for (int k = 0; k < NUM_ROMS; k++) begin
      if (src_idx == 4'(k)) begin
        rdr_val = (io_in[4*k +: 4] & ~IO_OUTPUT[4*k +: 4]) |
                  (io_out_q[4*k +: 4] & IO_OUTPUT[4*k +: 4]);
      end
    end
  end

  always_comb begin
    phase_d    = phase_q;
    valid_d    = valid_q;
    addr_lo_d  = addr_lo_q;
    sel_d      = sel_q;
    opa_d      = opa_q;
    iocmd_d    = iocmd_q;
    src_chip_d = src_chip_q;
    io_out_d   = io_out_q;
    rom_addr_d = rom_addr_q;

    if (phase_ev) begin
      if (sync) begin
        // SYNC starts a new cycle; anything in flight is abandoned.
        phase_d = PH_A1;
        valid_d = 1'b1;
        sel_d   = 1'b0;
        iocmd_d = 1'b0;
      end else begin
        phase_d = phase_q + 3'd1;
        case (phase_q)
          PH_A1: addr_lo_d[3:0] = data_in;
          PH_A2: addr_lo_d[7:4] = data_in;
          PH_A3: begin
            sel_d      = cmrom && chip_owned(data_in);
            rom_addr_d = AW'({fetch_idx, addr_lo_q});
          end
          PH_M2: begin
            opa_d   = data_in;
            iocmd_d = cmrom;
            sel_d   = 1'b0;
          end
          PH_X2: begin
            if (cmrom && !iocmd_q) begin
              src_chip_d = data_in;
            end
            if (valid_q && iocmd_q && (opa_q == 4'h2) && src_owned) begin
              for (int k = 0; k < NUM_ROMS; k++) begin
                if (src_idx == 4'(k)) begin
                  io_out_d[4*k +: 4] = (io_out_q[4*k +: 4] & ~IO_OUTPUT[4*k +: 4]) |
                                       (data_in & IO_OUTPUT[4*k +: 4]);
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Drive follows the phase register, so it releases one sysclk after the
  // closing clk2 fall and never overlaps another bank's window.
  always_comb begin
    data_oe_d  = 1'b0;
    data_out_d = 4'h0;
    if (valid_q) begin
      if (sel_q && (phase_q == PH_M1)) begin
        data_oe_d  = 1'b1;
        data_out_d = rom_data[7:4];
      end else if (sel_q && (phase_q == PH_M2)) begin
        data_oe_d  = 1'b1;
        data_out_d = rom_data[3:0];
      end else if (rdr_go && (phase_q == PH_X2)) begin
        data_oe_d  = 1'b1;
        data_out_d = rdr_val;
      end
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      clk2_q     <= 1'b0;
      phase_q    <= PH_X3;
      valid_q    <= 1'b0;
      addr_lo_q  <= 8'h00;
      sel_q      <= 1'b0;
      opa_q      <= 4'h0;
      iocmd_q    <= 1'b0;
      src_chip_q <= 4'h0;
      io_out_q   <= '0;
      data_oe_q  <= 1'b0;
      data_out_q <= 4'h0;
      rom_addr_q <= '0;
    end else begin
      clk2_q     <= clk2;
      phase_q    <= phase_d;
      valid_q    <= valid_d;
      addr_lo_q  <= addr_lo_d;
      sel_q      <= sel_d;
      opa_q      <= opa_d;
      iocmd_q    <= iocmd_d;
      src_chip_q <= src_chip_d;
      io_out_q   <= io_out_d;
      data_oe_q  <= data_oe_d;
      data_out_q <= data_out_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  assign data_oe  = data_oe_q;
  assign data_out = data_out_q;
  assign rom_addr = rom_addr_q;
  assign io_out   = io_out_q;

endmodule

// File: tb/tb_mcs4_rom_bank.sv
// tb/tb_mcs4_rom_bank.sv - directed bench for mcs4_rom_bank
module tb_mcs4_rom_bank;

  localparam int NUM_ROMS = 4;
  localparam int BASE_CHIP = 2;
  localparam logic [15:0] IO_OUTPUT = 16'hFF6F;
  localparam int AW = 10;

  logic        sysclk = 1'b0;
  logic        reset_n;
  logic        clk1, clk2, sync, cmrom;
  logic [3:0]  data_in;
  logic [3:0]  data_out;
  logic        data_oe;
  logic [AW-1:0] rom_addr;
  logic [7:0]  rom_data;
  logic [15:0] io_in;
  logic [15:0] io_out;

  int n_vec = 0;
  int n_fail = 0;

  mcs4_rom_bank #(
    .NUM_ROMS(NUM_ROMS), .BASE_CHIP(BASE_CHIP), .IO_OUTPUT(IO_OUTPUT), .AW(AW)
  ) dut (
    .sysclk(sysclk), .reset_n(reset_n), .clk1(clk1), .clk2(clk2),
    .sync(sync), .cmrom(cmrom), .data_in(data_in), .data_out(data_out),
    .data_oe(data_oe), .rom_addr(rom_addr), .rom_data(rom_data),
    .io_in(io_in), .io_out(io_out)
  );

  always #5 sysclk = ~sysclk;

  // Program store: 8'hD5 at 10'h1A7, otherwise low address byte xor 8'h3C.
  always @(posedge sysclk) begin
    rom_data <= (rom_addr == 10'h1A7) ? 8'hD5 : (rom_addr[7:0] ^ 8'h3C);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One 4004 phase: 8 sysclks, clk2 falls after the 6th; checks on every negedge.
  task automatic do_phase(input logic s, input logic cm, input logic [3:0] d,
                          input logic exp_oe, input logic [3:0] exp_do, input string tag);
    for (int i = 0; i < 8; i++) begin
      @(negedge sysclk);
      if (i == 0) begin
        sync = s;
        cmrom = cm;
        data_in = d;
      end
      clk1 = (i == 1 || i == 2);
      clk2 = (i == 4 || i == 5);
      chk({tag, ".oe"}, 32'(data_oe), 32'(exp_oe));
      if (exp_oe && i >= 2) chk({tag, ".do"}, 32'(data_out), 32'(exp_do));
    end
  endtask

  task automatic cycle(input logic [11:0] addr, input logic cm_a3,
                       input logic [3:0] opr, input logic [3:0] opa,
                       input logic cm_m2, input logic cm_x2, input logic [3:0] d_x2,
                       input logic exp_fetch, input logic exp_rdr, input logic [3:0] exp_rdr_do,
                       input string tag);
    do_phase(1'b0, 1'b0,  addr[3:0],  1'b0, 4'h0, {tag, ".A1"});
    do_phase(1'b0, 1'b0,  addr[7:4],  1'b0, 4'h0, {tag, ".A2"});
    do_phase(1'b0, cm_a3, addr[11:8], 1'b0, 4'h0, {tag, ".A3"});
    do_phase(1'b0, 1'b0,  opr, exp_fetch, opr, {tag, ".M1"});
    do_phase(1'b0, cm_m2, opa, exp_fetch, opa, {tag, ".M2"});
    do_phase(1'b0, 1'b0,  4'h0, 1'b0, 4'h0, {tag, ".X1"});
    do_phase(1'b0, cm_x2, d_x2, exp_rdr, exp_rdr_do, {tag, ".X2"});
    do_phase(1'b1, 1'b0,  4'h0, 1'b0, 4'h0, {tag, ".X3"});
  endtask

  initial begin
    reset_n = 1'b0;
    clk1 = 1'b0; clk2 = 1'b0; sync = 1'b0; cmrom = 1'b0;
    data_in = 4'h0; io_in = 16'h0000;
    repeat (3) @(negedge sysclk);
    chk("rst.oe", 32'(data_oe), 32'h0);
    chk("rst.do", 32'(data_out), 32'h0);
    chk("rst.rom_addr", 32'(rom_addr), 32'h0);
    chk("rst.io_out", 32'(io_out), 32'h0);
    reset_n = 1'b1;

    // Owned address but no SYNC seen yet: must stay off the bus.
    cycle(12'h3A7, 1'b1, 4'hD, 4'h5, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, "presync");

    cycle(12'h3A7, 1'b1, 4'hD, 4'h5, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, "fetch3A7");
    chk("fetch3A7.rom_addr", 32'(rom_addr), 32'h1A7);
    cycle(12'h0A7, 1'b1, 4'hD, 4'h5, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, "fetch0A7");
    chk("fetch0A7.rom_addr", 32'(rom_addr), 32'h2A7);
    cycle(12'h6A7, 1'b1, 4'hD, 4'h5, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, "fetch6A7");
    chk("fetch6A7.rom_addr", 32'(rom_addr), 32'h0A7);
    cycle(12'h200, 1'b1, 4'h3, 4'hC, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, "fetch200");
    chk("fetch200.rom_addr", 32'(rom_addr), 32'h000);
    cycle(12'h5FF, 1'b1, 4'hC, 4'h3, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, "fetch5FF");
    chk("fetch5FF.rom_addr", 32'(rom_addr), 32'h3FF);
    cycle(12'h3A7, 1'b0, 4'hD, 4'h5, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, "nocm3A7");

    // SRC chip 2 (local 0), WRR 9; then SRC chip 3 (local 1), WRR C.
    cycle(12'h010, 1'b1, 4'h2, 4'h1, 1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 4'h0, "src2");
    cycle(12'h011, 1'b1, 4'hE, 4'h2, 1'b1, 1'b0, 4'h9, 1'b0, 1'b0, 4'h0, "wrr9");
    chk("wrr9.io_out", 32'(io_out), 32'h0009);
    cycle(12'h012, 1'b1, 4'h2, 4'h1, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 4'h0, "src3");
    cycle(12'h013, 1'b1, 4'hE, 4'h2, 1'b1, 1'b0, 4'hC, 1'b0, 1'b0, 4'h0, "wrrC");
    chk("wrrC.io_out", 32'(io_out), 32'h0049);

    io_in = 16'h5A9F;
    cycle(12'h014, 1'b1, 4'hE, 4'hA, 1'b1, 1'b0, 4'hD, 1'b0, 1'b1, 4'hD, "rdr3");
    chk("rdr3.io_out", 32'(io_out), 32'h0049);
    cycle(12'h015, 1'b1, 4'hE, 4'h2, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 4'h0, "wrrF");
    chk("wrrF.io_out", 32'(io_out), 32'h0069);

    // Unowned chip 7: neither RDR nor WRR respond.
    cycle(12'h016, 1'b1, 4'h2, 4'h1, 1'b0, 1'b1, 4'h7, 1'b0, 1'b0, 4'h0, "src7");
    cycle(12'h017, 1'b1, 4'hE, 4'hA, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, "rdr7");
    cycle(12'h018, 1'b1, 4'hE, 4'h2, 1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 4'h0, "wrr7");
    chk("wrr7.io_out", 32'(io_out), 32'h0069);

    // Other I/O OPA on owned chip 2: no drive, no write.
    cycle(12'h019, 1'b1, 4'h2, 4'h1, 1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 4'h0, "src2b");
    cycle(12'h01A, 1'b1, 4'hE, 4'h1, 1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 4'h0, "opa1");
    chk("opa1.io_out", 32'(io_out), 32'h0069);

    // Abort: SYNC at M1 of an owned fetch; drive ends, next phase is A1.
    do_phase(1'b0, 1'b0, 4'h7, 1'b0, 4'h0, "abort.A1");
    do_phase(1'b0, 1'b0, 4'hA, 1'b0, 4'h0, "abort.A2");
    do_phase(1'b0, 1'b1, 4'h3, 1'b0, 4'h0, "abort.A3");
    do_phase(1'b1, 1'b0, 4'hD, 1'b1, 4'hD, "abort.M1");
    cycle(12'h200, 1'b1, 4'h3, 4'hC, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, "postabort");
    chk("postabort.rom_addr", 32'(rom_addr), 32'h000);

    // Reset during M2 of an owned fetch.
    do_phase(1'b0, 1'b0, 4'h7, 1'b0, 4'h0, "rstm.A1");
    do_phase(1'b0, 1'b0, 4'hA, 1'b0, 4'h0, "rstm.A2");
    do_phase(1'b0, 1'b1, 4'h3, 1'b0, 4'h0, "rstm.A3");
    do_phase(1'b0, 1'b0, 4'hD, 1'b1, 4'hD, "rstm.M1");
    @(negedge sysclk);
    data_in = 4'h5; clk1 = 1'b0; clk2 = 1'b0;
    chk("rstm.M2.oe_before", 32'(data_oe), 32'h1);
    @(negedge sysclk);
    clk1 = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("rstm.oe", 32'(data_oe), 32'h0);
    chk("rstm.do", 32'(data_out), 32'h0);
    chk("rstm.io_out", 32'(io_out), 32'h0);
    @(negedge sysclk);
    reset_n = 1'b1;
    clk1 = 1'b0;
    cycle(12'h3A7, 1'b1, 4'hD, 4'h5, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, "postrst.nosync");
    cycle(12'h3A7, 1'b1, 4'hD, 4'h5, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, "postrst.fetch");
    chk("postrst.rom_addr", 32'(rom_addr), 32'h1A7);
    chk("postrst.io_out", 32'(io_out), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
